// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier (MUL/UMULH/SMULH) with start/busy/done handshake
module mul_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_result, w_res;
  logic [2*WIDTH-1:0] r_acc, w_acc, w_prod;
  logic [WIDTH:0] w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic r_sign, r_high, r_zero, w_accept, w_last, w_smulh;
  always_comb begin
    w_smulh = i_op == 2'b10;
    w_accept = i_start && r_state != S_RUN;
    w_last = r_state == S_RUN && r_cnt == CNT_W'(WIDTH-1);
    w_next = w_accept ? S_RUN : r_state == S_RUN ? (w_last ? S_DONE : S_RUN) : S_IDLE;
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mplier[0] ? r_mcand : {WIDTH{1'b0}}};
    w_acc = {w_sum, r_acc[WIDTH-1:1]};
    w_prod = r_sign ? -w_acc : w_acc;
    w_res = r_high ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
  end
  always_ff @(posedge clk)
    r_state <= !reset ? S_IDLE : w_next;
  // SMULH runs on magnitudes; the product sign is reapplied on the final iteration
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand <= '0;
      r_mplier <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_sign <= 1'b0;
      r_high <= 1'b0;
      r_result <= '0;
      r_zero <= 1'b1;
    end else if (w_accept) begin
      r_mcand <= (w_smulh && i_a[WIDTH-1]) ? -i_a : i_a;
      r_mplier <= (w_smulh && i_b[WIDTH-1]) ? -i_b : i_b;
      r_acc <= '0;
      r_cnt <= '0;
      r_sign <= w_smulh && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_high <= i_op[0] ^ i_op[1];
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc;
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_res;
        r_zero <= w_res == '0;
      end
    end
  end
  assign o_busy = r_state == S_RUN;
  assign o_done = r_state == S_DONE;
  assign o_result = r_result;
  assign o_zero = r_zero;
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed self-checking bench for mul_unit
module tb_mul_unit;
  logic clk = 1'b0, reset = 1'b0, i_start = 1'b0;
  logic [63:0] i_a = '0, i_b = '0;
  logic [1:0] i_op = '0;
  logic o_busy, o_done, o_zero;
  logic [63:0] o_result;
  int tests = 0, fails = 0;
  mul_unit dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_a(i_a), .i_b(i_b), .i_op(i_op),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_zero(o_zero)
  );
  always #5 clk = ~clk;
  task automatic go(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    @(negedge clk);
    i_a = a;
    i_b = b;
    i_op = op;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a = '1;
    i_b = '1;
    i_op = 2'b11;
  endtask
  task automatic wait_done();
    repeat (64) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({o_busy, o_done, o_zero} !== 3'b001) begin
      fails++;
      $display("FAIL reset_flags: busy/done/zero=%b expected 001", {o_busy, o_done, o_zero});
    end
    tests++;
    if (o_result !== 64'h0) begin
      fails++;
      $display("FAIL reset_result: got %h expected 0", o_result);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_latency();
    int bad = 0;
    go(64'd3, 64'd5, 2'b00);
    if (!(o_busy === 1'b1 && o_done === 1'b0)) bad++;
    repeat (63) begin
      @(posedge clk);
      #1;
      if (!(o_busy === 1'b1 && o_done === 1'b0)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL latency_busy: %0d cycles wrong expected 0", bad);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({o_busy, o_done, o_zero} !== 3'b010 || o_result !== 64'hF) begin
      fails++;
      $display("FAIL latency_done: busy/done/zero=%b result=%h expected 010 f", {o_busy, o_done, o_zero}, o_result);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({o_busy, o_done} !== 2'b00 || o_result !== 64'hF) begin
      fails++;
      $display("FAIL latency_after: busy/done=%b result=%h expected 00 f", {o_busy, o_done}, o_result);
    end
  endtask
  task automatic test_ones();
    go('1, '1, 2'b01);
    wait_done();
    tests++;
    if (o_done !== 1'b1 || o_result !== 64'hFFFF_FFFF_FFFF_FFFE || o_zero !== 1'b0) begin
      fails++;
      $display("FAIL umulh_ones: done=%b result=%h zero=%b expected 1 fffffffffffffffe 0", o_done, o_result, o_zero);
    end
    go('1, '1, 2'b00);
    wait_done();
    tests++;
    if (o_done !== 1'b1 || o_result !== 64'h1 || o_zero !== 1'b0) begin
      fails++;
      $display("FAIL mul_ones: done=%b result=%h zero=%b expected 1 1 0", o_done, o_result, o_zero);
    end
  endtask
  task automatic test_smulh();
    go(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b10);
    wait_done();
    tests++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFF || o_zero !== 1'b0) begin
      fails++;
      $display("FAIL smulh_neg: result=%h zero=%b expected ffffffffffffffff 0", o_result, o_zero);
    end
    go(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10);
    wait_done();
    tests++;
    if (o_result !== 64'h4000_0000_0000_0000) begin
      fails++;
      $display("FAIL smulh_min: result=%h expected 4000000000000000", o_result);
    end
    go(64'd5, 64'd7, 2'b10);
    wait_done();
    tests++;
    if (o_result !== 64'h0 || o_zero !== 1'b1) begin
      fails++;
      $display("FAIL smulh_small: result=%h zero=%b expected 0 1", o_result, o_zero);
    end
    go(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01);
    wait_done();
    tests++;
    if (o_result !== 64'h4000_0000_0000_0000) begin
      fails++;
      $display("FAIL umulh_min: result=%h expected 4000000000000000", o_result);
    end
  endtask
  task automatic test_zero();
    go(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 2'b00);
    wait_done();
    tests++;
    if (o_result !== 64'h0 || o_zero !== 1'b1) begin
      fails++;
      $display("FAIL zero_set: result=%h zero=%b expected 0 1", o_result, o_zero);
    end
    go(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2'b00);
    wait_done();
    tests++;
    if (o_result !== 64'h1 || o_zero !== 1'b0) begin
      fails++;
      $display("FAIL zero_clear: result=%h zero=%b expected 1 0", o_result, o_zero);
    end
    go(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b11);
    wait_done();
    tests++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      fails++;
      $display("FAIL reserved_op: result=%h expected fffffffffffffffa", o_result);
    end
  endtask
  task automatic test_restart_ignored();
    go(64'd3, 64'd5, 2'b00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    i_a = 64'd7;
    i_b = 64'd7;
    i_op = 2'b01;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (53) @(posedge clk);
    #1;
    tests++;
    if (o_done !== 1'b1 || o_result !== 64'hF) begin
      fails++;
      $display("FAIL restart_ignored: done=%b result=%h expected 1 f", o_done, o_result);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({o_busy, o_done} !== 2'b00) begin
      fails++;
      $display("FAIL restart_idle: busy/done=%b expected 00", {o_busy, o_done});
    end
  endtask
  task automatic test_back_to_back();
    go(64'd2, 64'd3, 2'b00);
    repeat (63) @(posedge clk);
    @(negedge clk);
    i_a = 64'd4;
    i_b = 64'd5;
    i_op = 2'b00;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({o_busy, o_done} !== 2'b01 || o_result !== 64'h6) begin
      fails++;
      $display("FAIL b2b_first: busy/done=%b result=%h expected 01 6", {o_busy, o_done}, o_result);
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
    tests++;
    if ({o_busy, o_done} !== 2'b10 || o_result !== 64'h6) begin
      fails++;
      $display("FAIL b2b_accept: busy/done=%b result=%h expected 10 6", {o_busy, o_done}, o_result);
    end
    repeat (63) @(posedge clk);
    #1;
    tests++;
    if (o_done !== 1'b0 || o_result !== 64'h6) begin
      fails++;
      $display("FAIL b2b_early: done=%b result=%h expected 0 6", o_done, o_result);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_done !== 1'b1 || o_result !== 64'h14) begin
      fails++;
      $display("FAIL b2b_second: done=%b result=%h expected 1 14", o_done, o_result);
    end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    go(64'd9, 64'd9, 2'b00);
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({o_busy, o_done, o_zero} !== 3'b001 || o_result !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid: busy/done/zero=%b result=%h expected 001 0", {o_busy, o_done, o_zero}, o_result);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (o_done || o_busy) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_no_done: %0d active cycles expected 0", seen);
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_ones();
    test_smulh();
    test_zero();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
